// File: rtl/mult_pkg.sv
// Shared constants and types for the iterative HI/LO multiplier.
package mult_pkg;

    // Operand width of the MIPS integer datapath.
    localparam int MULT_WIDTH = 32;

    // Iteration counter must hold the value WIDTH itself.
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter width for an arbitrary operand width.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Decoder/datapath-facing bundle of the multiplier: request, control, status and HI/LO.
interface mult_unit_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) ();

    logic             Start_mult;
    logic             Mult_sign;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    // Decoder / pipeline side.
    modport master (
        output Start_mult, Mult_sign, SrcA, SrcB, Flush,
        input  Busy, Done, Hi, Lo
    );

    // Multiplier side.
    modport slave (
        input  Start_mult, Mult_sign, SrcA, SrcB, Flush,
        output Busy, Done, Hi, Lo
    );

endinterface

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration on the {carry, upper, multiplier} accumulator.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0]   upper;
    logic [2*WIDTH:0] summed;

    // Conditional add into the upper half, then a right shift that keeps the carry.
    // The top bit is always 0 on entry, so the W+1-bit sum cannot overflow.
    always_comb begin
        upper = acc[2*WIDTH:WIDTH];
        if (acc[0]) begin
            upper = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
        summed   = {upper, acc[WIDTH-1:0]};
        acc_next = summed >> 1;
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative WIDTH x WIDTH multiplier owning HI/LO. Sign conditioning and the FSM
// live here; the per-cycle shift-add is in mult_step.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic        clk,
    input logic        rst_n,
    mult_unit_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic               load;
    logic               step;
    logic               finish;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand magnitudes and result sign; 0x80..0 negates to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        mag_a  = (bus.Mult_sign && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
        mag_b  = (bus.Mult_sign && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
        neg_in = bus.Mult_sign & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
    end

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    // Final product from the last step's output, so HI/LO update on the same edge
    // the count expires.
    always_comb begin
        prod_mag = acc_next[2*WIDTH-1:0];
        prod     = neg ? -prod_mag : prod_mag;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath strobes; Flush wins over both start and completion.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start_mult && !bus.Flush) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.Flush) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(1)) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, multiplicand, counter and sign flag. The upper half and carry are
    // cleared at start; the multiplier magnitude rides in the low half and is
    // consumed one bit per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            acc   <= {{(WIDTH+1){1'b0}}, mag_b};
            mcand <= mag_a;
            cnt   <= CW'(WIDTH);
            neg   <= neg_in;
        end else if (step) begin
            acc   <= acc_next;
            cnt   <= cnt - CW'(1);
        end
    end

    // HI/LO and the Done pulse; HI/LO only ever change atomically on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= finish;
            if (finish) begin
                hi_q <= prod[2*WIDTH-1:WIDTH];
                lo_q <= prod[WIDTH-1:0];
            end
        end
    end

    assign bus.Busy = (state == RUN);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed scenarios plus randomized operations
// against an arithmetic reference product.
module tb_mult_unit;
    import mult_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_unit_if #(.WIDTH(MULT_WIDTH)) bus ();

    mult_unit #(.WIDTH(MULT_WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: full-precision product from plain integer arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint    sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble operands to prove they were captured.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.Start_mult = 1'b1;
        bus.Mult_sign  = s;
        bus.SrcA       = a;
        bus.SrcB       = b;
        tick();
        bus.Start_mult = 1'b0;
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.Mult_sign  = 1'($urandom);
    endtask

    // Follow an operation to its Done pulse (bounded). lat counts edges from the
    // start edge inclusive; held drops if HI/LO move before Done.
    task automatic wait_done(output int busy_cyc, output int lat, output bit held);
        logic [31:0] h0, l0;
        h0 = bus.Hi;
        l0 = bus.Lo;
        busy_cyc = 0;
        lat      = 1;
        held     = 1'b1;
        while (1) begin
            if (bus.Busy) busy_cyc++;
            if (bus.Done) break;
            if (bus.Hi !== h0 || bus.Lo !== l0) held = 1'b0;
            if (lat >= 60) break;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all 0",
                     bus.Busy, bus.Done, bus.Hi, bus.Lo);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_max();
        int bc, lat;
        bit held;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(bc, lat, held);
        n_cmp++;
        if (bc != 32 || lat != 33 || bus.Done !== 1'b1 || !held) begin
            n_err++;
            $display("FAIL umax_timing: got busy=%0d lat=%0d done=%b held=%0d, want 32/33/1/1",
                     bc, lat, bus.Done, held);
        end
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'hFFFF_FFFE_0000_0001) begin
            n_err++;
            $display("FAIL umax_value: got %h_%h want fffffffe_00000001", bus.Hi, bus.Lo);
        end
        tick();
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: got done=%b busy=%b want 0/0", bus.Done, bus.Busy);
        end
    endtask

    task automatic test_signed();
        int bc, lat;
        bit held;
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'hFFFF_FFFF_FFFF_FFF1 || lat != 33) begin
            n_err++;
            $display("FAIL signed_m3x5: got %h_%h lat=%0d want ffffffff_fffffff1 lat=33",
                     bus.Hi, bus.Lo, lat);
        end
        tick();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'h4000_0000_0000_0000 || lat != 33) begin
            n_err++;
            $display("FAIL signed_minmin: got %h_%h lat=%0d want 40000000_00000000 lat=33",
                     bus.Hi, bus.Lo, lat);
        end
    endtask

    task automatic test_hold_ignore();
        int bc, lat, dn, done_lat;
        bit held;
        tick();
        start_op(32'd2, 32'h8000_0001, 1'b0);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'h0000_0001_0000_0002) begin
            n_err++;
            $display("FAIL preload: got %h_%h want 00000001_00000002", bus.Hi, bus.Lo);
        end
        tick();
        start_op(32'd7, 32'd6, 1'b0);
        lat = 1; dn = 0; done_lat = 0; held = 1'b1;
        repeat (45) begin
            if (lat == 10) begin
                bus.Start_mult = 1'b1;
                bus.SrcA       = 32'd9;
                bus.SrcB       = 32'd9;
            end else begin
                bus.Start_mult = 1'b0;
            end
            if (bus.Done) begin
                dn++;
                if (done_lat == 0) done_lat = lat;
            end else if (bus.Busy && {bus.Hi, bus.Lo} !== 64'h0000_0001_0000_0002) begin
                held = 1'b0;
            end
            tick();
            lat++;
        end
        n_cmp++;
        if (dn != 1 || done_lat != 33 || !held) begin
            n_err++;
            $display("FAIL hold_ignore_ctl: got dones=%0d done_lat=%0d held=%0d want 1/33/1",
                     dn, done_lat, held);
        end
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'd42 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ignore_val: got %h_%h busy=%b want 00000000_0000002a busy=0",
                     bus.Hi, bus.Lo, bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        int bc, lat;
        bit held;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        start_op(a, b, 1'b0);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== ref_prod(a, b, 1'b0)) begin
            n_err++;
            $display("FAIL b2b_first: got %h_%h want %h", bus.Hi, bus.Lo, ref_prod(a, b, 1'b0));
        end
        start_op(32'd3, 32'd4, 1'b0);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy: got busy=%b want 1", bus.Busy);
        end
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== 64'd12 || lat != 33 || bus.Done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: got %h_%h lat=%0d want 00000000_0000000c lat=33",
                     bus.Hi, bus.Lo, lat);
        end
    endtask

    task automatic test_flush();
        int bc, lat, dn;
        bit held;
        logic [63:0] keep;
        tick();
        keep = {bus.Hi, bus.Lo};
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (14) tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mid: got busy=%b done=%b want 0/0", bus.Busy, bus.Done);
        end
        dn = 0; held = 1'b1;
        repeat (30) begin
            if (bus.Done) dn++;
            if ({bus.Hi, bus.Lo} !== keep) held = 1'b0;
            tick();
        end
        n_cmp++;
        if (dn != 0 || !held) begin
            n_err++;
            $display("FAIL flush_quiet: got dones=%0d held=%0d want 0/1", dn, held);
        end
        // Start together with Flush in IDLE is dropped.
        bus.Flush      = 1'b1;
        bus.Start_mult = 1'b1;
        tick();
        bus.Flush      = 1'b0;
        bus.Start_mult = 1'b0;
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_start_idle: got busy=%b want 0", bus.Busy);
        end
        // Flush on the completion edge wins.
        start_op(32'd1000, 32'd1000, 1'b0);
        repeat (31) tick();
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_last_cycle: got busy=%b want 1", bus.Busy);
        end
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || {bus.Hi, bus.Lo} !== keep) begin
            n_err++;
            $display("FAIL flush_on_finish: got done=%b busy=%b hilo=%h_%h want 0/0/%h",
                     bus.Done, bus.Busy, bus.Hi, bus.Lo, keep);
        end
        start_op(32'hFFFF_FFF9, 32'd11, 1'b1);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== ref_prod(32'hFFFF_FFF9, 32'd11, 1'b1) || lat != 33) begin
            n_err++;
            $display("FAIL after_flush: got %h_%h lat=%0d want %h lat=33",
                     bus.Hi, bus.Lo, lat, ref_prod(32'hFFFF_FFF9, 32'd11, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        int bc, lat;
        bit held;
        logic [31:0] a, b;
        tick();
        start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== 66'd0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.Busy, bus.Done, bus.Hi, bus.Lo);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.Busy, bus.Done, bus.Hi, bus.Lo);
        end
        a = $urandom;
        b = $urandom;
        start_op(a, b, 1'b1);
        wait_done(bc, lat, held);
        n_cmp++;
        if ({bus.Hi, bus.Lo} !== ref_prod(a, b, 1'b1) || lat != 33 || bc != 32) begin
            n_err++;
            $display("FAIL after_reset: got %h_%h lat=%0d busy=%0d want %h 33/32",
                     bus.Hi, bus.Lo, lat, bc, ref_prod(a, b, 1'b1));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int bc, lat;
        bit held;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            a = pick_operand();
            b = pick_operand();
            s = 1'($urandom);
            start_op(a, b, s);
            wait_done(bc, lat, held);
            n_cmp++;
            if ({bus.Hi, bus.Lo} !== ref_prod(a, b, s) || lat != 33 || bc != 32 || !held) begin
                n_err++;
                $display("FAIL rand_%0d: a=%h b=%h s=%b got %h_%h lat=%0d busy=%0d held=%0d want %h 33/32/1",
                         i, a, b, s, bus.Hi, bus.Lo, lat, bc, held, ref_prod(a, b, s));
            end
        end
    endtask

    initial begin
        bus.Start_mult = 1'b0;
        bus.Mult_sign  = 1'b0;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.Flush      = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_hold_ignore();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
